// File: rtl/btb_pkg.sv
// Shared types and constants for the branch target buffer.
// Counter encodings, per-entry control state and reset values.
package btb_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } btb_ctr_e;

    // Resettable part of an entry; tag and target sit in parameter-sized arrays without reset.
    typedef struct packed {
        logic       valid;
        logic [1:0] ctr;
        logic       jump;
    } btb_entry_t;

    localparam btb_entry_t  ENTRY_RESET = '{valid: 1'b0, ctr: STRONG_NT, jump: 1'b0};
    localparam logic [31:0] STAT_RESET  = 32'h0000_0000;
    localparam logic [31:0] STAT_MAX    = 32'hFFFF_FFFF;

endpackage

// File: rtl/btb_sat_ctr.sv
// Two-bit saturating direction counter next-state logic.
module btb_sat_ctr
    import btb_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_nxt
);

    always_comb begin
        ctr_nxt = ctr;
        if (taken) begin
            if (ctr != STRONG_T) ctr_nxt = ctr + 2'd1;
        end else begin
            if (ctr != STRONG_NT) ctr_nxt = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit counters, zero-latency lookup and E-stage update.
// Define BTB_STATS_EN to build the resolved-control / mispredict statistics counters.
module btb_predictor
    import btb_pkg::*;
#(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned XLEN    = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [XLEN-1:0] i_pc_F,
    output logic            o_pred_taken,
    output logic [XLEN-1:0] o_pred_target,
    input  logic            i_upd_vld,
    input  logic [XLEN-1:0] i_upd_pc,
    input  logic [XLEN-1:0] i_upd_target,
    input  logic            i_upd_taken,
    input  logic            i_upd_is_jump,
    input  logic            i_upd_pred_taken,
    input  logic [XLEN-1:0] i_upd_pred_target,
    output logic            o_mispred,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic [31:0]     o_stat_ctrl,
    output logic [31:0]     o_stat_mispred
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    btb_entry_t       ctl_q [ENTRIES];
    logic [TAG_W-1:0] tag_q [ENTRIES];
    logic [XLEN-2:0]  tgt_q [ENTRIES];

    logic [IDX_W-1:0] look_idx;
    logic [TAG_W-1:0] look_tag;
    logic             look_hit;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic [1:0]       ctr_nxt;
    logic             mispred;
    logic [1:0]       unused_pc_bits;

    assign unused_pc_bits = i_pc_F[1:0];

    // Lookup
    assign look_idx = i_pc_F[IDX_W+1:2];
    assign look_tag = i_pc_F[XLEN-1:IDX_W+2];
    assign look_hit = ctl_q[look_idx].valid && (tag_q[look_idx] == look_tag);

    assign o_pred_taken  = look_hit && (ctl_q[look_idx].jump || ctl_q[look_idx].ctr[1]);
    assign o_pred_target = look_hit ? {tgt_q[look_idx], 1'b0} : '0;

    // Update
    assign upd_idx = i_upd_pc[IDX_W+1:2];
    assign upd_tag = i_upd_pc[XLEN-1:IDX_W+2];
    assign upd_hit = ctl_q[upd_idx].valid && (tag_q[upd_idx] == upd_tag);

    btb_sat_ctr u_sat_ctr (
        .ctr     (ctl_q[upd_idx].ctr),
        .taken   (i_upd_taken),
        .ctr_nxt (ctr_nxt)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctl_q[i] <= ENTRY_RESET;
            end
        end else if (i_upd_vld) begin
            if (upd_hit) begin
                ctl_q[upd_idx].ctr <= ctr_nxt;
            end else if (i_upd_taken) begin
                ctl_q[upd_idx] <= '{valid: 1'b1,
                                    ctr:   (i_upd_is_jump ? STRONG_T : WEAK_T),
                                    jump:  i_upd_is_jump};
            end
        end
    end

    // Taken updates either allocate or refresh the target; the tag is unchanged on a hit.
    always_ff @(posedge i_clk) begin
        if (i_reset && i_upd_vld && i_upd_taken) begin
            tag_q[upd_idx] <= upd_tag;
            tgt_q[upd_idx] <= i_upd_target[XLEN-1:1];
        end
    end

    // Recovery
    assign mispred = i_upd_vld &&
                     ((i_upd_pred_taken != i_upd_taken) ||
                      (i_upd_taken && (i_upd_pred_target != i_upd_target)));
    assign o_mispred     = mispred;
    assign o_redirect_pc = i_upd_taken ? {i_upd_target[XLEN-1:1], 1'b0}
                                       : i_upd_pc + XLEN'(4);

`ifdef BTB_STATS_EN
    logic [31:0] stat_ctrl_q;
    logic [31:0] stat_mispred_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            stat_ctrl_q    <= STAT_RESET;
            stat_mispred_q <= STAT_RESET;
        end else begin
            if (i_upd_vld && (stat_ctrl_q != STAT_MAX)) begin
                stat_ctrl_q <= stat_ctrl_q + 32'd1;
            end
            if (mispred && (stat_mispred_q != STAT_MAX)) begin
                stat_mispred_q <= stat_mispred_q + 32'd1;
            end
        end
    end

    assign o_stat_ctrl    = stat_ctrl_q;
    assign o_stat_mispred = stat_mispred_q;
`else
    assign o_stat_ctrl    = STAT_RESET;
    assign o_stat_mispred = STAT_RESET;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench for btb_predictor: driver queues expectations, negedge monitor checks them.
module tb_btb_predictor;

`ifdef BTB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic [31:0] i_pc_F = '0;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;
    logic        i_upd_vld = 1'b0;
    logic [31:0] i_upd_pc = '0;
    logic [31:0] i_upd_target = '0;
    logic        i_upd_taken = 1'b0;
    logic        i_upd_is_jump = 1'b0;
    logic        i_upd_pred_taken = 1'b0;
    logic [31:0] i_upd_pred_target = '0;
    logic        o_mispred;
    logic [31:0] o_redirect_pc;
    logic [31:0] o_stat_ctrl;
    logic [31:0] o_stat_mispred;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        bit          kind_pred;
        bit          kind_upd;
        bit          kind_stat;
        logic        taken;
        logic [31:0] value;
        logic [31:0] value2;
    } exp_t;

    exp_t sb[$];

    btb_predictor #(.ENTRIES(64), .XLEN(32)) dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_pc_F            (i_pc_F),
        .o_pred_taken      (o_pred_taken),
        .o_pred_target     (o_pred_target),
        .i_upd_vld         (i_upd_vld),
        .i_upd_pc          (i_upd_pc),
        .i_upd_target      (i_upd_target),
        .i_upd_taken       (i_upd_taken),
        .i_upd_is_jump     (i_upd_is_jump),
        .i_upd_pred_taken  (i_upd_pred_taken),
        .i_upd_pred_target (i_upd_pred_target),
        .o_mispred         (o_mispred),
        .o_redirect_pc     (o_redirect_pc),
        .o_stat_ctrl       (o_stat_ctrl),
        .o_stat_mispred    (o_stat_mispred)
    );

    always #5 i_clk = ~i_clk;

    // Drive one cycle's worth of inputs just after the rising edge.
    task automatic step(input logic [31:0] pc_f, input logic vld, input logic [31:0] upc,
                        input logic [31:0] utgt, input logic tk, input logic jmp,
                        input logic ptk, input logic [31:0] ptgt);
        @(posedge i_clk);
        #1;
        i_pc_F            = pc_f;
        i_upd_vld         = vld;
        i_upd_pc          = upc;
        i_upd_target      = utgt;
        i_upd_taken       = tk;
        i_upd_is_jump     = jmp;
        i_upd_pred_taken  = ptk;
        i_upd_pred_target = ptgt;
    endtask

    task automatic idle(input logic [31:0] pc_f);
        step(pc_f, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic exp_pred(input string n, input logic tk, input logic [31:0] tgt);
        exp_t e;
        e = '{name: n, kind_pred: 1'b1, kind_upd: 1'b0, kind_stat: 1'b0,
              taken: tk, value: tgt, value2: 32'h0};
        sb.push_back(e);
    endtask

    task automatic exp_upd(input string n, input logic mis, input logic [31:0] redir);
        exp_t e;
        e = '{name: n, kind_pred: 1'b0, kind_upd: 1'b1, kind_stat: 1'b0,
              taken: mis, value: redir, value2: 32'h0};
        sb.push_back(e);
    endtask

    task automatic exp_stat(input string n, input logic [31:0] ctrl, input logic [31:0] mis);
        exp_t e;
        e = '{name: n, kind_pred: 1'b0, kind_upd: 1'b0, kind_stat: 1'b1,
              taken: 1'b0, value: ctrl, value2: mis};
        sb.push_back(e);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (e.kind_pred) begin
                    if (o_pred_taken !== e.taken || o_pred_target !== e.value) begin
                        errors++;
                        $display("FAIL %s: pred got taken=%0b target=%h, want taken=%0b target=%h",
                                 e.name, o_pred_taken, o_pred_target, e.taken, e.value);
                    end
                end else if (e.kind_upd) begin
                    if (o_mispred !== e.taken || o_redirect_pc !== e.value) begin
                        errors++;
                        $display("FAIL %s: got mispred=%0b redirect=%h, want mispred=%0b redirect=%h",
                                 e.name, o_mispred, o_redirect_pc, e.taken, e.value);
                    end
                end else begin
                    if (o_stat_ctrl !== e.value || o_stat_mispred !== e.value2) begin
                        errors++;
                        $display("FAIL %s: got ctrl=%0d mispred=%0d, want ctrl=%0d mispred=%0d",
                                 e.name, o_stat_ctrl, o_stat_mispred, e.value, e.value2);
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge i_clk);
        idle(32'h40);
        i_reset = 1'b1;
        exp_pred("reset_lookup", 1'b0, 32'h0);
        exp_upd("reset_idle_upd", 1'b0, 32'h4);
        exp_stat("reset_stats", 32'd0, 32'd0);

        // Allocate 0x40 -> 0x100; lookup in the same cycle sees the old miss.
        step(32'h40, 1'b1, 32'h40, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
        exp_pred("alloc_same_cycle", 1'b0, 32'h0);
        exp_upd("alloc_mispred", 1'b1, 32'h100);
        idle(32'h40);
        exp_pred("alloc_hit", 1'b1, 32'h100);

        // Not-taken training 10 -> 01 -> 00.
        step(32'h40, 1'b1, 32'h40, 32'h0, 1'b0, 1'b0, 1'b1, 32'h100);
        exp_pred("nt1_pre_update", 1'b1, 32'h100);
        exp_upd("nt1_mispred", 1'b1, 32'h44);
        step(32'h40, 1'b1, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        exp_pred("nt2_weak_nt", 1'b0, 32'h100);
        exp_upd("nt2_correct", 1'b0, 32'h44);
        idle(32'h40);
        exp_pred("nt_strong_nt", 1'b0, 32'h100);

        // Saturate at 00, then one taken must give 01 (still not-taken).
        step(32'h40, 1'b1, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        exp_upd("sat_low_correct", 1'b0, 32'h44);
        step(32'h40, 1'b1, 32'h40, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
        exp_upd("sat_low_taken_mis", 1'b1, 32'h100);
        idle(32'h40);
        exp_pred("sat_low_no_wrap", 1'b0, 32'h100);

        // Aliasing entry at 0x140 evicts 0x40.
        step(32'h140, 1'b1, 32'h140, 32'h200, 1'b1, 1'b0, 1'b0, 32'h0);
        exp_pred("alias_pre", 1'b0, 32'h0);
        exp_upd("alias_mispred", 1'b1, 32'h200);
        idle(32'h140);
        exp_pred("alias_hit", 1'b1, 32'h200);
        idle(32'h40);
        exp_pred("alias_evicted", 1'b0, 32'h0);

        // Jump at 0x80 with odd target; bit0 must be cleared, pred target differs.
        step(32'h80, 1'b1, 32'h80, 32'h301, 1'b1, 1'b1, 1'b1, 32'h300);
        exp_pred("same_cycle_miss", 1'b0, 32'h0);
        exp_upd("jump_target_mis", 1'b1, 32'h300);
        idle(32'h80);
        exp_pred("jump_hit", 1'b1, 32'h300);

        // Not-taken miss allocates nothing.
        step(32'h1C0, 1'b1, 32'h1C0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        exp_upd("nt_miss_correct", 1'b0, 32'h1C4);
        idle(32'h1C0);
        exp_pred("nt_miss_no_alloc", 1'b0, 32'h0);

        // Fields present but vld=0: no mispredict, no change.
        step(32'h140, 1'b0, 32'h140, 32'h400, 1'b1, 1'b0, 1'b0, 32'h0);
        exp_upd("novld_no_mispred", 1'b0, 32'h400);
        idle(32'h140);
        exp_pred("novld_no_change", 1'b1, 32'h200);

        // Fall-through wraps modulo 2^32.
        step(32'h140, 1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        exp_upd("redirect_wrap", 1'b0, 32'h0);
        idle(32'h140);
        exp_stat("stats_run1", STATS ? 32'd9 : 32'd0, STATS ? 32'd5 : 32'd0);

        // Reset with an update present: update dropped, everything cleared.
        step(32'h240, 1'b1, 32'h240, 32'h500, 1'b1, 1'b0, 1'b0, 32'h0);
        i_reset = 1'b0;
        idle(32'h240);
        i_reset = 1'b1;
        exp_pred("reset_drops_update", 1'b0, 32'h0);
        exp_stat("reset_clears_stats", 32'd0, 32'd0);
        idle(32'h140);
        exp_pred("reset_clears_0x140", 1'b0, 32'h0);
        idle(32'h80);
        exp_pred("reset_clears_0x80", 1'b0, 32'h0);

        // Five updates, two mispredicts.
        step(32'h0, 1'b1, 32'h40, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
        exp_upd("s1_mis", 1'b1, 32'h100);
        step(32'h0, 1'b1, 32'h40, 32'h100, 1'b1, 1'b0, 1'b1, 32'h100);
        exp_upd("s2_ok", 1'b0, 32'h100);
        step(32'h0, 1'b1, 32'h40, 32'h0, 1'b0, 1'b0, 1'b1, 32'h100);
        exp_upd("s3_mis", 1'b1, 32'h44);
        step(32'h40, 1'b1, 32'h40, 32'h100, 1'b1, 1'b0, 1'b1, 32'h100);
        exp_pred("s4_pre_weak_t", 1'b1, 32'h100);
        exp_upd("s4_ok", 1'b0, 32'h100);
        step(32'h0, 1'b1, 32'h44, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        exp_upd("s5_ok", 1'b0, 32'h48);
        idle(32'h40);
        exp_pred("s_final_hit", 1'b1, 32'h100);
        exp_stat("stats_run2", STATS ? 32'd5 : 32'd0, STATS ? 32'd2 : 32'd0);
        idle(32'h44);
        exp_pred("s_nt_miss", 1'b0, 32'h0);

        i_reset = 1'b0;
        idle(32'h40);
        i_reset = 1'b1;
        exp_stat("midrun_reset_stats", 32'd0, 32'd0);
        exp_pred("midrun_reset_lookup", 1'b0, 32'h0);

        @(posedge i_clk);
        @(negedge i_clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
